// File: rtl/ni_local.sv
// ni_local: network interface between a core and the router local port.
// TX path stamps outgoing packets with source and injection time and injects
// them one per cycle when the router can take them. RX path filters arriving
// flits by destination, computes network latency and buffers them for the core.
module ni_local #(
    parameter logic [3:0]  NODE_ID  = 4'd2,
    parameter int unsigned DATASIZE = 40,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // core transmit side
    input  logic                core_tx_valid,
    output logic                core_tx_ready,
    input  logic [3:0]          core_tx_dst,
    input  logic [1:0]          core_tx_type,
    input  logic [21:0]         core_tx_data,
    // router local input
    output logic [DATASIZE-1:0] rt_data_out,
    output logic                rt_valid_out,
    input  logic                rt_full_in,
    // router local output
    input  logic [DATASIZE-1:0] rt_data_in,
    input  logic                rt_valid_in,
    // core receive side
    output logic                core_rx_valid,
    input  logic                core_rx_ready,
    output logic [3:0]          core_rx_src,
    output logic [1:0]          core_rx_type,
    output logic [21:0]         core_rx_data,
    output logic [7:0]          core_rx_latency,
    // status
    output logic [7:0]          drop_cnt,
    output logic [7:0]          err_cnt,
    output logic [7:0]          now
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned RXW = 36;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DATASIZE-1:0] tx_mem [DEPTH];
    logic [PW-1:0]       tx_wr_q, tx_wr_d;
    logic [PW-1:0]       tx_rd_q, tx_rd_d;
    logic                tx_full, tx_empty;
    logic                tx_push, tx_pop;
    logic [DATASIZE-1:0] tx_flit;

    logic                rt_valid_q, rt_valid_d;
    logic [DATASIZE-1:0] rt_data_q, rt_data_d;

    logic [RXW-1:0]      rx_mem [DEPTH];
    logic [PW-1:0]       rx_wr_q, rx_wr_d;
    logic [PW-1:0]       rx_rd_q, rx_rd_d;
    logic                rx_full, rx_empty;
    logic                rx_push, rx_pop;
    logic [RXW-1:0]      rx_entry;
    logic [RXW-1:0]      rx_head;

    logic [3:0]          rx_in_src;
    logic [3:0]          rx_in_dst;
    logic [7:0]          rx_in_ts;
    logic [21:0]         rx_in_data;
    logic [1:0]          rx_in_type;
    logic [7:0]          rx_in_lat;
    logic                misroute, overflow;

    logic [7:0]          now_q, now_d;
    logic [7:0]          drop_q, drop_d;
    logic [7:0]          err_q, err_d;

    // ------------------------------------------------------------------
    // Queue status: pointers carry one extra wrap bit so full/empty are exact
    // ------------------------------------------------------------------
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                      (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                      (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

    // ------------------------------------------------------------------
    // TX handshake and flit assembly
    // ------------------------------------------------------------------
    assign core_tx_ready = !tx_full;
    assign tx_push       = core_tx_valid && !tx_full;
    // occupancy before the edge decides injection; no same-cycle bypass
    assign tx_pop        = !tx_empty && !rt_full_in;
    assign tx_flit       = {NODE_ID, core_tx_dst, now_q, core_tx_data, core_tx_type};

    // ------------------------------------------------------------------
    // RX decode and classification
    // ------------------------------------------------------------------
    assign rx_in_src  = rt_data_in[39:36];
    assign rx_in_dst  = rt_data_in[35:32];
    assign rx_in_ts   = rt_data_in[31:24];
    assign rx_in_data = rt_data_in[23:2];
    assign rx_in_type = rt_data_in[1:0];
    assign rx_in_lat  = now_q - rx_in_ts;
    assign rx_entry   = {rx_in_src, rx_in_type, rx_in_data, rx_in_lat};

    assign rx_pop   = !rx_empty && core_rx_ready;
    assign misroute = rt_valid_in && (rx_in_dst != NODE_ID);
    // a full queue still accepts when the core frees a slot in the same cycle
    assign overflow = rt_valid_in && (rx_in_dst == NODE_ID) && rx_full && !rx_pop;
    assign rx_push  = rt_valid_in && (rx_in_dst == NODE_ID) && (!rx_full || rx_pop);

    // ------------------------------------------------------------------
    // Core-facing RX outputs present the head combinationally
    // ------------------------------------------------------------------
    assign rx_head         = rx_mem[rx_rd_q[AW-1:0]];
    assign core_rx_valid   = !rx_empty;
    assign core_rx_src     = rx_head[35:32];
    assign core_rx_type    = rx_head[31:30];
    assign core_rx_data    = rx_head[29:8];
    assign core_rx_latency = rx_head[7:0];

    assign rt_data_out  = rt_data_q;
    assign rt_valid_out = rt_valid_q;
    assign drop_cnt     = drop_q;
    assign err_cnt      = err_q;
    assign now          = now_q;

    // Next-state for TX pointers and the registered injection port
    always_comb begin
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        rt_valid_d = 1'b0;
        rt_data_d  = rt_data_q;
        if (tx_push) begin
            tx_wr_d = tx_wr_q + PW'(1);
        end
        if (tx_pop) begin
            tx_rd_d    = tx_rd_q + PW'(1);
            rt_valid_d = 1'b1;
            rt_data_d  = tx_mem[tx_rd_q[AW-1:0]];
        end
    end

    // Next-state for RX pointers, saturating counters and timestamp
    always_comb begin
        rx_wr_d = rx_wr_q;
        rx_rd_d = rx_rd_q;
        drop_d  = drop_q;
        err_d   = err_q;
        now_d   = now_q + 8'd1;
        if (rx_push) begin
            rx_wr_d = rx_wr_q + PW'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PW'(1);
        end
        if (overflow && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (misroute && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // State registers, cleared asynchronously so queued flits vanish on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rt_valid_q <= 1'b0;
            rt_data_q  <= '0;
            now_q      <= '0;
            drop_q     <= '0;
            err_q      <= '0;
        end else begin
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rt_valid_q <= rt_valid_d;
            rt_data_q  <= rt_data_d;
            now_q      <= now_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    // Queue storage; contents are meaningless outside the pointer window
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q[AW-1:0]] <= tx_flit;
        end
        if (rx_push) begin
            rx_mem[rx_wr_q[AW-1:0]] <= rx_entry;
        end
    end

endmodule

// File: tb/tb_ni_local.sv
// Testbench for ni_local: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_ni_local;

    localparam logic [3:0] NODE  = 4'd2;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_tx_valid;
    logic        core_tx_ready;
    logic [3:0]  core_tx_dst;
    logic [1:0]  core_tx_type;
    logic [21:0] core_tx_data;
    logic [39:0] rt_data_out;
    logic        rt_valid_out;
    logic        rt_full_in;
    logic [39:0] rt_data_in;
    logic        rt_valid_in;
    logic        core_rx_valid;
    logic        core_rx_ready;
    logic [3:0]  core_rx_src;
    logic [1:0]  core_rx_type;
    logic [21:0] core_rx_data;
    logic [7:0]  core_rx_latency;
    logic [7:0]  drop_cnt;
    logic [7:0]  err_cnt;
    logic [7:0]  now;

    always #5 clk = ~clk;

    ni_local #(.NODE_ID(4'd2), .DATASIZE(40), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
        .core_tx_dst(core_tx_dst), .core_tx_type(core_tx_type), .core_tx_data(core_tx_data),
        .rt_data_out(rt_data_out), .rt_valid_out(rt_valid_out), .rt_full_in(rt_full_in),
        .rt_data_in(rt_data_in), .rt_valid_in(rt_valid_in),
        .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
        .core_rx_src(core_rx_src), .core_rx_type(core_rx_type), .core_rx_data(core_rx_data),
        .core_rx_latency(core_rx_latency),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt), .now(now)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mkflit(input logic [3:0] s, input logic [3:0] d,
                                           input logic [7:0] ts, input logic [21:0] dat,
                                           input logic [1:0] ty);
        return {s, d, ts, dat, ty};
    endfunction

    task automatic idle_inputs();
        core_tx_valid = 1'b0;
        core_tx_dst   = '0;
        core_tx_type  = '0;
        core_tx_data  = '0;
        rt_full_in    = 1'b0;
        rt_data_in    = '0;
        rt_valid_in   = 1'b0;
        core_rx_ready = 1'b0;
    endtask

    // leaves the bench at a negedge with reset just released and now == 0
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        tv;
        logic [3:0]  td;
        logic [21:0] tdat;
        logic [1:0]  tt;
        logic        full;
        logic        rv;
        logic [39:0] rflit;
        logic        rr;
        logic        e_txr;
        logic        e_rtv;
        logic [39:0] e_rtd;
        logic        e_rxv;
        logic [3:0]  e_src;
        logic [1:0]  e_type;
        logic [21:0] e_data;
        logic [7:0]  e_lat;
        logic [7:0]  e_err;
        logic [7:0]  e_drop;
        logic [7:0]  e_now;
    } vec_t;

    vec_t vecs[10];

    // reference model state
    int          m_now, m_err, m_drop;
    logic [39:0] m_txq[$];
    logic [35:0] m_rxq[$];
    logic        m_rtv;
    logic [39:0] m_rtd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] f1, f2, r1, r2;
        int acc, cnt, seen;
        logic [21:0] first_d, last_d;

        rst_n = 1'b1;
        idle_inputs();

        // ---------------- table-driven vectors ----------------
        f1 = mkflit(4'd2, 4'd5, 8'h03, 22'h1234, 2'd1);
        f2 = mkflit(4'd2, 4'd3, 8'h07, 22'h3FFFFF, 2'd3);
        r1 = mkflit(4'd7, 4'd2, 8'd252, 22'h2AAAA, 2'd2);
        r2 = mkflit(4'd1, 4'd7, 8'd0, 22'h5, 2'd0);
        //          tv td    tdat       tt full rv rflit rr  txr rtv rtd  rxv src type data     lat err drop now
        vecs[0] = '{0, 4'd0, 22'h0,      0, 0,  0, '0,  0,  1,  0,  '0, 0,  0,  0,   22'h0,   0,  0,  0,  8'd1};
        vecs[1] = '{0, 4'd0, 22'h0,      0, 0,  0, '0,  0,  1,  0,  '0, 0,  0,  0,   22'h0,   0,  0,  0,  8'd2};
        vecs[2] = '{0, 4'd0, 22'h0,      0, 0,  0, '0,  0,  1,  0,  '0, 0,  0,  0,   22'h0,   0,  0,  0,  8'd3};
        vecs[3] = '{1, 4'd5, 22'h1234,   1, 0,  0, '0,  0,  1,  0,  '0, 0,  0,  0,   22'h0,   0,  0,  0,  8'd4};
        vecs[4] = '{0, 4'd0, 22'h0,      0, 0,  0, '0,  0,  1,  1,  f1, 0,  0,  0,   22'h0,   0,  0,  0,  8'd5};
        vecs[5] = '{0, 4'd0, 22'h0,      0, 0,  1, r1,  0,  1,  0,  f1, 1,  7,  2,   22'h2AAAA, 9, 0,  0,  8'd6};
        vecs[6] = '{0, 4'd0, 22'h0,      0, 0,  1, r2,  0,  1,  0,  f1, 1,  7,  2,   22'h2AAAA, 9, 1,  0,  8'd7};
        vecs[7] = '{1, 4'd3, 22'h3FFFFF, 3, 1,  0, '0,  1,  1,  0,  f1, 0,  0,  0,   22'h0,   0,  1,  0,  8'd8};
        vecs[8] = '{0, 4'd0, 22'h0,      0, 1,  0, '0,  0,  1,  0,  f1, 0,  0,  0,   22'h0,   0,  1,  0,  8'd9};
        vecs[9] = '{0, 4'd0, 22'h0,      0, 0,  0, '0,  0,  1,  1,  f2, 0,  0,  0,   22'h0,   0,  1,  0,  8'd10};

        do_reset();
        #1;
        check("rst_now", now, 0);
        check("rst_rtv", rt_valid_out, 0);
        check("rst_rtd", rt_data_out, 0);
        check("rst_rxv", core_rx_valid, 0);
        check("rst_txr", core_tx_ready, 1);
        for (int i = 0; i < 10; i++) begin
            core_tx_valid = vecs[i].tv;
            core_tx_dst   = vecs[i].td;
            core_tx_data  = vecs[i].tdat;
            core_tx_type  = vecs[i].tt;
            rt_full_in    = vecs[i].full;
            rt_valid_in   = vecs[i].rv;
            rt_data_in    = vecs[i].rflit;
            core_rx_ready = vecs[i].rr;
            @(negedge clk);
            check($sformatf("vec%0d_txr", i), core_tx_ready, vecs[i].e_txr);
            check($sformatf("vec%0d_rtv", i), rt_valid_out, vecs[i].e_rtv);
            check($sformatf("vec%0d_rtd", i), rt_data_out, vecs[i].e_rtd);
            check($sformatf("vec%0d_rxv", i), core_rx_valid, vecs[i].e_rxv);
            if (vecs[i].e_rxv) begin
                check($sformatf("vec%0d_rxhead", i),
                      {core_rx_src, core_rx_type, core_rx_data, core_rx_latency},
                      {vecs[i].e_src, vecs[i].e_type, vecs[i].e_data, vecs[i].e_lat});
            end
            check($sformatf("vec%0d_err", i), err_cnt, vecs[i].e_err);
            check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].e_drop);
            check($sformatf("vec%0d_now", i), now, vecs[i].e_now);
        end

        // ---------------- TX fill under backpressure, then drain ----------------
        do_reset();
        rt_full_in = 1'b1;
        acc  = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            core_tx_valid = 1'b1;
            core_tx_dst   = 4'd9;
            core_tx_data  = 22'(k);
            core_tx_type  = 2'd0;
            if (core_tx_ready) acc++;
            @(negedge clk);
            if (rt_valid_out) seen++;
        end
        core_tx_valid = 1'b0;
        check("txfill_accepted", acc, 4);
        check("txfill_ready_low", core_tx_ready, 0);
        check("txfill_no_inject", seen, 0);
        rt_full_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("drain%0d_valid", j), rt_valid_out, 1);
            check($sformatf("drain%0d_data", j), rt_data_out[23:2], 22'(j));
        end
        @(negedge clk);
        check("drain_end_valid", rt_valid_out, 0);
        check("drain_end_ready", core_tx_ready, 1);

        // ---------------- latency wrap and misroute ----------------
        do_reset();
        for (int n = 0; n < 300 && now != 8'd4; n++) @(negedge clk);
        check("wait_now4", now, 4);
        rt_valid_in = 1'b1;
        rt_data_in  = mkflit(4'd9, 4'd2, 8'd250, 22'h155, 2'd2);
        @(negedge clk);
        rt_valid_in = 1'b0;
        check("lat_rxv", core_rx_valid, 1);
        check("lat_value", core_rx_latency, 10);
        check("lat_src", core_rx_src, 9);
        check("lat_data", core_rx_data, 22'h155);
        rt_valid_in = 1'b1;
        rt_data_in  = mkflit(4'd9, 4'd7, 8'd0, 22'h1, 2'd0);
        @(negedge clk);
        rt_valid_in = 1'b0;
        check("misroute_err", err_cnt, 1);
        check("misroute_rxv", core_rx_valid, 1);
        check("misroute_head", core_rx_data, 22'h155);

        // ---------------- RX overflow and full-with-pop acceptance ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rt_valid_in = 1'b1;
            rt_data_in  = mkflit(4'd1, 4'd2, 8'd0, 22'(i), 2'd0);
            @(negedge clk);
        end
        check("ovf_drop", drop_cnt, 2);
        check("ovf_rxv", core_rx_valid, 1);
        rt_data_in    = mkflit(4'd1, 4'd2, 8'd0, 22'd6, 2'd0);
        core_rx_ready = 1'b1;
        @(negedge clk);
        rt_valid_in = 1'b0;
        check("fullpop_drop", drop_cnt, 2);
        cnt     = 0;
        first_d = '0;
        last_d  = '0;
        for (int k = 0; k < 10 && core_rx_valid; k++) begin
            if (cnt == 0) first_d = core_rx_data;
            last_d = core_rx_data;
            cnt++;
            @(negedge clk);
        end
        check("fullpop_count", cnt, 4);
        check("fullpop_first", first_d, 22'd1);
        check("fullpop_last", last_d, 22'd6);

        // ---------------- reset mid-operation ----------------
        do_reset();
        core_tx_valid = 1'b1;
        core_tx_dst   = 4'd4;
        core_tx_data  = 22'h7;
        @(negedge clk);
        core_tx_valid = 1'b0;
        @(negedge clk);
        rt_full_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            core_tx_valid = 1'b1;
            core_tx_data  = 22'(i + 1);
            rt_valid_in   = 1'b1;
            rt_data_in    = mkflit(4'd3, (i < 2) ? 4'd2 : 4'd8, 8'd0, 22'(i), 2'd1);
            @(negedge clk);
        end
        core_tx_valid = 1'b0;
        rt_valid_in   = 1'b0;
        check("prerst_rtd", rt_data_out[23:2], 22'h7);
        check("prerst_rxv", core_rx_valid, 1);
        check("prerst_err", err_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncrst_rtv", rt_valid_out, 0);
        check("asyncrst_rtd", rt_data_out, 0);
        check("asyncrst_rxv", core_rx_valid, 0);
        check("asyncrst_now", now, 0);
        check("asyncrst_err", err_cnt, 0);
        check("asyncrst_drop", drop_cnt, 0);
        check("asyncrst_txr", core_tx_ready, 1);
        @(negedge clk);
        rst_n         = 1'b1;
        rt_full_in    = 1'b0;
        core_rx_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rt_valid_out || core_rx_valid) seen++;
        end
        check("postrst_no_flit", seen, 0);

        // ---------------- err_cnt saturation ----------------
        do_reset();
        rt_valid_in = 1'b1;
        rt_data_in  = mkflit(4'd0, 4'd7, 8'd0, 22'h0, 2'd0);
        repeat (300) @(negedge clk);
        rt_valid_in = 1'b0;
        @(negedge clk);
        check("sat_err", err_cnt, 255);
        check("sat_drop", drop_cnt, 0);
        check("sat_rxv", core_rx_valid, 0);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_now  = 0;
        m_err  = 0;
        m_drop = 0;
        m_rtv  = 1'b0;
        m_rtd  = '0;
        m_txq.delete();
        m_rxq.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic tv, full, rv, rr;
            logic [3:0] td, rdst;
            logic [21:0] tdat;
            logic [1:0] tt;
            logic [39:0] rfl;
            bit rx_pop;

            check("rnd_txr", core_tx_ready, m_txq.size() < DEPTH);
            check("rnd_rtv", rt_valid_out, m_rtv);
            check("rnd_rtd", rt_data_out, m_rtd);
            check("rnd_rxv", core_rx_valid, m_rxq.size() > 0);
            if (m_rxq.size() > 0)
                check("rnd_rxhead", {core_rx_src, core_rx_type, core_rx_data, core_rx_latency}, m_rxq[0]);
            check("rnd_err", err_cnt, m_err);
            check("rnd_drop", drop_cnt, m_drop);
            check("rnd_now", now, m_now);

            tv   = ($urandom % 4) != 0;
            td   = 4'($urandom);
            tdat = 22'($urandom);
            tt   = 2'($urandom);
            full = ($urandom % 3) == 0;
            rv   = ($urandom % 2) == 0;
            rdst = (($urandom % 5) != 0) ? NODE : 4'($urandom);
            rfl  = mkflit(4'($urandom), rdst, 8'($urandom), 22'($urandom), 2'($urandom));
            rr   = ($urandom % 100) < (((cyc / 250) % 2) ? 85 : 20);
            core_tx_valid = tv;
            core_tx_dst   = td;
            core_tx_data  = tdat;
            core_tx_type  = tt;
            rt_full_in    = full;
            rt_valid_in   = rv;
            rt_data_in    = rfl;
            core_rx_ready = rr;

            // TX: injection decided by pre-edge occupancy, then the push
            if (m_txq.size() > 0 && !full) begin
                m_rtv = 1'b1;
                m_rtd = m_txq.pop_front();
            end else begin
                m_rtv = 1'b0;
            end
            if (tv && core_tx_ready)
                m_txq.push_back({NODE, td, 8'(m_now), tdat, tt});

            // RX: classify the arrival against pre-edge fullness
            rx_pop = (m_rxq.size() > 0) && rr;
            if (rv) begin
                if (rdst != NODE) begin
                    if (m_err < 255) m_err++;
                end else if (m_rxq.size() == DEPTH && !rx_pop) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    if (rx_pop) void'(m_rxq.pop_front());
                    rx_pop = 0;
                    m_rxq.push_back({rfl[39:36], rfl[1:0], rfl[23:2], 8'((m_now - int'(rfl[31:24])) & 255)});
                end
            end
            if (rx_pop) void'(m_rxq.pop_front());
            m_now = (m_now + 1) % 256;

            @(negedge clk);
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
